i2c_slave_responder: RTL and testbench

- Synthesizable I2C slave that sits on the scl/sda lines driven by the iicmb multi-bus master (DUT).
- Closes the loop for Wishbone-driven bench flows, e.g. set bus, start, address 0x44, write 0x78, stop.
- Decodes START/STOP, matches a 7-bit address, ACKs it, and delivers written bytes to a user port.
- For reads, fetches bytes from a user port and shifts them onto sda.
- Oversamples scl/sda with the system clock. No clock stretching.

---
 rtl/i2c_slave_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
// I2C slave responder: oversampled START/STOP detection, 7-bit address match,
// ACKs every addressed byte, streams written bytes out and read bytes in.
module i2c_slave_responder #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h22,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_o,
   output logic [7:0] wr_data_o,
   output logic       wr_valid_o,
   output logic       rd_req_o,
   input  logic [7:0] rd_data_i,
   output logic       start_o,
   output logic       stop_o,
   output logic       busy_o
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
   logic scl_hist_r, sda_hist_r;
   logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_cond_s, stop_cond_s;

   state_t     state_r, nx_state_s;
   logic [3:0] bit_cnt_r, nx_bit_cnt_s;
   logic [7:0] shift_r, nx_shift_s;
   logic [7:0] wr_data_r, nx_wr_data_s;
   logic       rw_r, nx_rw_s;
   logic       ack_phase_r, nx_ack_phase_s;
   logic       sda_r, nx_sda_s;
   logic       wr_valid_r, nx_wr_valid_s;
   logic       rd_req_r, nx_rd_req_s;
   logic       start_r, nx_start_s;
   logic       stop_r, nx_stop_s;
   logic       busy_r, nx_busy_s;

   // Input synchronizers plus history flops; reset to the idle (released) bus level.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_sync_r <= {SYNC_STAGES{1'b1}};
         sda_sync_r <= {SYNC_STAGES{1'b1}};
         scl_hist_r <= 1'b1;
         sda_hist_r <= 1'b1;
      end else begin
         scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
         sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
         scl_hist_r <= scl_sync_r[SYNC_STAGES-1];
         sda_hist_r <= sda_sync_r[SYNC_STAGES-1];
      end
   end

   assign scl_s        = scl_sync_r[SYNC_STAGES-1];
   assign sda_s        = sda_sync_r[SYNC_STAGES-1];
   assign scl_rise_s   = scl_s & ~scl_hist_r;
   assign scl_fall_s   = ~scl_s & scl_hist_r;
   assign start_cond_s = scl_s & sda_hist_r & ~sda_s;
   assign stop_cond_s  = scl_s & ~sda_hist_r & sda_s;

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r     <= IDLE;
         bit_cnt_r   <= 4'd0;
         shift_r     <= 8'h00;
         wr_data_r   <= 8'h00;
         rw_r        <= 1'b0;
         ack_phase_r <= 1'b0;
         sda_r       <= 1'b1;
         wr_valid_r  <= 1'b0;
         rd_req_r    <= 1'b0;
         start_r     <= 1'b0;
         stop_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= nx_state_s;
         bit_cnt_r   <= nx_bit_cnt_s;
         shift_r     <= nx_shift_s;
         wr_data_r   <= nx_wr_data_s;
         rw_r        <= nx_rw_s;
         ack_phase_r <= nx_ack_phase_s;
         sda_r       <= nx_sda_s;
         wr_valid_r  <= nx_wr_valid_s;
         rd_req_r    <= nx_rd_req_s;
         start_r     <= nx_start_s;
         stop_r      <= nx_stop_s;
         busy_r      <= nx_busy_s;
      end
   end

   // Next-state logic; bus conditions take priority over scl edges.
   always_comb begin
      nx_state_s     = state_r;
      nx_bit_cnt_s   = bit_cnt_r;
      nx_shift_s     = shift_r;
      nx_wr_data_s   = wr_data_r;
      nx_rw_s        = rw_r;
      nx_ack_phase_s = ack_phase_r;
      nx_sda_s       = sda_r;
      nx_wr_valid_s  = 1'b0;
      nx_rd_req_s    = 1'b0;
      nx_start_s     = 1'b0;
      nx_stop_s      = 1'b0;
      nx_busy_s      = busy_r;
      if (stop_cond_s) begin
         nx_state_s     = IDLE;
         nx_bit_cnt_s   = 4'd0;
         nx_ack_phase_s = 1'b0;
         nx_sda_s       = 1'b1;
         nx_stop_s      = 1'b1;
         nx_busy_s      = 1'b0;
      end else if (start_cond_s) begin
         nx_state_s     = ADDR;
         nx_bit_cnt_s   = 4'd0;
         nx_ack_phase_s = 1'b0;
         nx_sda_s       = 1'b1;
         nx_start_s     = 1'b1;
         nx_busy_s      = 1'b1;
      end else begin
         case (state_r)
            IDLE, WAIT_STOP: begin
               nx_sda_s = 1'b1;
            end
            ADDR, WR_BYTE: begin
               if (scl_rise_s) begin
                  nx_shift_s = {shift_r[6:0], sda_s};
                  if (bit_cnt_r == 4'd7) begin
                     nx_bit_cnt_s   = 4'd0;
                     nx_ack_phase_s = 1'b0;
                     if (state_r == WR_BYTE) begin
                        nx_wr_data_s  = {shift_r[6:0], sda_s};
                        nx_wr_valid_s = 1'b1;
                        nx_state_s    = WR_ACK;
                     end else if (shift_r[6:0] == SLAVE_ADDR) begin
                        nx_rw_s     = sda_s;
                        nx_rd_req_s = sda_s;
                        nx_state_s  = ADDR_ACK;
                     end else begin
                        nx_state_s  = WAIT_STOP;
                     end
                  end else begin
                     nx_bit_cnt_s = bit_cnt_r + 4'd1;
                  end
               end else begin
                  nx_shift_s = shift_r;
               end
            end
            // First fall pulls ACK low, the second ends the ACK bit.
            ADDR_ACK, WR_ACK: begin
               if (scl_fall_s) begin
                  if (!ack_phase_r) begin
                     nx_sda_s       = 1'b0;
                     nx_ack_phase_s = 1'b1;
                  end else if ((state_r == WR_ACK) || !rw_r) begin
                     nx_sda_s       = 1'b1;
                     nx_ack_phase_s = 1'b0;
                     nx_bit_cnt_s   = 4'd0;
                     nx_state_s     = WR_BYTE;
                  end else begin
                     nx_shift_s     = rd_data_i;
                     nx_sda_s       = rd_data_i[7];
                     nx_ack_phase_s = 1'b0;
                     nx_bit_cnt_s   = 4'd1;
                     nx_state_s     = RD_BYTE;
                  end
               end else begin
                  nx_sda_s = sda_r;
               end
            end
            RD_BYTE: begin
               if (scl_fall_s) begin
                  if (bit_cnt_r == 4'd8) begin
                     nx_sda_s       = 1'b1;
                     nx_bit_cnt_s   = 4'd0;
                     nx_ack_phase_s = 1'b0;
                     nx_state_s     = RD_ACK;
                  end else begin
                     nx_shift_s   = {shift_r[6:0], 1'b0};
                     nx_sda_s     = shift_r[6];
                     nx_bit_cnt_s = bit_cnt_r + 4'd1;
                  end
               end else begin
                  nx_sda_s = sda_r;
               end
            end
            RD_ACK: begin
               if (scl_rise_s && !ack_phase_r) begin
                  if (!sda_s) begin
                     nx_rd_req_s    = 1'b1;
                     nx_ack_phase_s = 1'b1;
                  end else begin
                     nx_state_s     = WAIT_STOP;
                  end
               end else if (scl_fall_s && ack_phase_r) begin
                  nx_shift_s     = rd_data_i;
                  nx_sda_s       = rd_data_i[7];
                  nx_ack_phase_s = 1'b0;
                  nx_bit_cnt_s   = 4'd1;
                  nx_state_s     = RD_BYTE;
               end else begin
                  nx_sda_s = sda_r;
               end
            end
            default: begin
               nx_state_s = IDLE;
               nx_sda_s   = 1'b1;
            end
         endcase
      end
   end

   assign sda_o      = sda_r;
   assign wr_data_o  = wr_data_r;
   assign wr_valid_o = wr_valid_r;
   assign rd_req_o   = rd_req_r;
   assign start_o    = start_r;
   assign stop_o     = stop_r;
   assign busy_o     = busy_r;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-level I2C master with randomized timing
// and data, and a transaction-level expectation model checked every cycle.
module tb_i2c_slave_responder;
   localparam logic [6:0] SA  = 7'h22;
   localparam int         SS  = 2;
   localparam int         LAT = SS + 1;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic [7:0] rd_data_i = 8'h00;
   logic       sda_bus;
   logic       sda_o, wr_valid_o, rd_req_o, start_o, stop_o, busy_o;
   logic [7:0] wr_data_o;

   assign sda_bus = sda_m & sda_o;

   i2c_slave_responder #(.SLAVE_ADDR(SA), .SYNC_STAGES(SS)) dut (
      .clk_i(clk), .rst_i(rst_i), .scl_i(scl_m), .sda_i(sda_bus), .sda_o(sda_o),
      .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o), .rd_req_o(rd_req_o),
      .rd_data_i(rd_data_i), .start_o(start_o), .stop_o(stop_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int   checks = 0, errors = 0;
   int   T = 6;
   bit   drive_ok = 1'b0;
   logic [7:0] exp_wr[$], feed[$], tx_q[$], rd_log[$];
   int   rd_cnt = 0, exp_rdreq = 0, wr_cnt = 0, start_cnt = 0, stop_cnt = 0;
   bit   d_start [LAT];
   bit   d_stop  [LAT];
   bit   pscl = 1'b1, psda = 1'b1, mbusy = 1'b0, es, ep, rs, rp;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic clear_counts();
      wr_cnt = 0; start_cnt = 0; stop_cnt = 0; rd_cnt = 0; exp_rdreq = 0;
      rd_log.delete();
   endtask

   // Per-cycle compare: bus conditions seen on the pins must appear on the
   // pulses exactly LAT cycles later; busy follows them; sda only driven when allowed.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_i) begin
            for (int i = 0; i < LAT; i++) begin d_start[i] = 1'b0; d_stop[i] = 1'b0; end
            pscl = scl_m; psda = sda_bus; mbusy = 1'b0;
         end else begin
            rs = pscl & scl_m & psda & ~sda_bus;
            rp = pscl & scl_m & ~psda & sda_bus;
            es = d_start[LAT-1];
            ep = d_stop[LAT-1];
            for (int i = LAT-1; i > 0; i--) begin
               d_start[i] = d_start[i-1];
               d_stop[i]  = d_stop[i-1];
            end
            d_start[0] = rs; d_stop[0] = rp;
            pscl = scl_m; psda = sda_bus;
            if (es) mbusy = 1'b1;
            if (ep) mbusy = 1'b0;
            check("start_o", int'(start_o), int'(es));
            check("stop_o", int'(stop_o), int'(ep));
            check("busy_o", int'(busy_o), int'(mbusy));
            if (!drive_ok) check("sda_release", int'(sda_o), 1);
            if (start_o) start_cnt++;
            if (stop_o) stop_cnt++;
            if (wr_valid_o) begin
               wr_cnt++;
               check("wr_expected", int'(exp_wr.size() > 0), 1);
               if (exp_wr.size() > 0) check("wr_data", int'(wr_data_o), int'(exp_wr.pop_front()));
            end
            if (rd_req_o) begin
               rd_cnt++;
               if (feed.size() > 0) rd_data_i = feed.pop_front();
            end
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clock_bit(input bit b, output bit seen, output bit so);
      sda_m = b;    tick(T);
      scl_m = 1'b1; tick(T);
      seen = sda_bus; so = sda_o;
      tick(T);
      scl_m = 1'b0; tick(T);
   endtask

   task automatic send_start();
      sda_m = 1'b1; tick(T);
      scl_m = 1'b1; tick(T);
      sda_m = 1'b0; tick(T);
      scl_m = 1'b0; tick(T);
   endtask

   task automatic send_stop();
      sda_m = 1'b0; tick(T);
      scl_m = 1'b1; tick(T);
      sda_m = 1'b1; tick(2*T + LAT);
   endtask

   task automatic write_byte(input logic [7:0] b, input bit exp_ack, input bit keep);
      bit s, so;
      for (int i = 7; i >= 0; i--) begin
         if (i == 0 && exp_ack) drive_ok = 1'b1;
         clock_bit(b[i], s, so);
      end
      clock_bit(1'b1, s, so);
      check("ack", int'(!s), int'(exp_ack));
      if (!keep) drive_ok = 1'b0;
   endtask

   task automatic read_byte(input bit ack, input logic [7:0] exp);
      bit s, so;
      logic [7:0] v;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         clock_bit(1'b1, s, so);
         v = {v[6:0], s};
      end
      check("rd_byte", int'(v), int'(exp));
      rd_log.push_back(v);
      clock_bit(ack ? 1'b0 : 1'b1, s, so);
      check("rd_ack_release", int'(so), 1);
      if (!ack) drive_ok = 1'b0;
   endtask

   // One transaction; data bytes come from tx_q. Without stop_end the next call issues Sr.
   task automatic do_xfer(input logic [6:0] addr, input bit rw, input bit stop_end);
      bit match;
      int n;
      logic [7:0] rexp[$];
      match = (addr == SA);
      n = tx_q.size();
      T = $urandom_range(5, 9);
      send_start();
      if (match && rw) begin
         foreach (tx_q[i]) feed.push_back(tx_q[i]);
         rexp = tx_q;
         exp_rdreq++;
      end
      write_byte({addr, rw}, match, match && rw);
      if (rw) begin
         if (match) begin
            for (int i = 0; i < n; i++) begin
               read_byte(i < n-1, rexp[i]);
               if (i < n-1) exp_rdreq++;
            end
         end
      end else begin
         foreach (tx_q[i]) begin
            if (match) exp_wr.push_back(tx_q[i]);
            write_byte(tx_q[i], match, 1'b0);
         end
      end
      tx_q.delete();
      if (stop_end) begin
         send_stop();
         check("wr_drained", exp_wr.size(), 0);
         check("rd_req_count", rd_cnt, exp_rdreq);
      end
   endtask

   initial begin : stim
      bit s, so;
      logic [7:0] b, rb;
      logic [6:0] a;
      bit rw, se;
      int n;
      tick(5);
      rst_i = 1'b0;
      tick(2);
      check("rst_sda_o", int'(sda_o), 1);
      check("rst_wr_data", int'(wr_data_o), 0);
      check("rst_wr_valid", int'(wr_valid_o), 0);
      check("rst_rd_req", int'(rd_req_o), 0);
      check("rst_start", int'(start_o), 0);
      check("rst_stop", int'(stop_o), 0);
      check("rst_busy", int'(busy_o), 0);

      clear_counts();
      tx_q = {8'h78};
      do_xfer(7'h22, 1'b0, 1'b1);
      check("w_wr_data", int'(wr_data_o), 32'h78);
      check("w_wr_cnt", wr_cnt, 1);
      check("w_start_cnt", start_cnt, 1);
      check("w_stop_cnt", stop_cnt, 1);
      check("w_busy", int'(busy_o), 0);

      clear_counts();
      tx_q = {8'h55};
      do_xfer(7'h23, 1'b0, 1'b1);
      check("mm_wr_cnt", wr_cnt, 0);
      check("mm_stop_cnt", stop_cnt, 1);

      clear_counts();
      tx_q = {8'hA5, 8'h3C};
      do_xfer(7'h22, 1'b1, 1'b1);
      check("r_byte0", int'(rd_log[0]), 32'hA5);
      check("r_byte1", int'(rd_log[1]), 32'h3C);
      check("r_rd_req_cnt", rd_cnt, 2);

      clear_counts();
      tx_q = {8'h12};
      do_xfer(7'h22, 1'b0, 1'b0);
      tx_q = {8'h9E};
      do_xfer(7'h22, 1'b1, 1'b1);
      check("sr_wr_data", int'(wr_data_o), 32'h12);
      check("sr_wr_cnt", wr_cnt, 1);
      check("sr_start_cnt", start_cnt, 2);
      check("sr_stop_cnt", stop_cnt, 1);
      check("sr_rd_byte", int'(rd_log[0]), 32'h9E);

      clear_counts();
      T = 6;
      send_start();
      write_byte(8'h44, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), s, so);
      send_stop();
      check("ab_wr_cnt", wr_cnt, 0);
      check("ab_wr_data", int'(wr_data_o), 32'h12);
      check("ab_busy", int'(busy_o), 0);

      clear_counts();
      send_start();
      b = 8'h44;
      for (int i = 7; i >= 0; i--) begin
         if (i == 0) drive_ok = 1'b1;
         clock_bit(b[i], s, so);
      end
      check("rs_ack_driven", int'(sda_o), 0);
      rst_i = 1'b1;
      tick(1);
      rst_i = 1'b0;
      drive_ok = 1'b0;
      check("rs_sda_o", int'(sda_o), 1);
      check("rs_pulses", int'({wr_valid_o, rd_req_o, start_o, stop_o}), 0);
      check("rs_busy", int'(busy_o), 0);
      check("rs_wr_data", int'(wr_data_o), 0);
      clock_bit(1'b1, s, so);
      send_stop();
      clear_counts();
      rb = 8'($urandom_range(0, 255));
      tx_q = {rb};
      do_xfer(7'h22, 1'b0, 1'b1);
      check("rs_after_cnt", wr_cnt, 1);
      check("rs_after_start", start_cnt, 1);

      clear_counts();
      for (int k = 0; k < 14; k++) begin
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SA;
         if (a == SA && $urandom_range(0, 5) == 0) a = SA ^ 7'h01;
         rw = 1'($urandom_range(0, 1));
         n  = $urandom_range(1, 3);
         se = (k == 13) ? 1'b1 : ($urandom_range(0, 2) != 0);
         for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
         do_xfer(a, rw, se);
      end
      check("rand_busy_end", int'(busy_o), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
